// File: rtl/instr_halfword_assembler_pkg.sv
// Shared types and encoding helpers for the instruction halfword assembler.
// Holds the halfword/instruction widths, the position of the group field in
// hw0, and the group -> length mapping used to size each instruction.
package instr_halfword_assembler_pkg;

    localparam int HW_WIDTH           = 16;
    localparam int INSTR_MAX_HW       = 3;
    localparam int INSTR_WIDTH        = HW_WIDTH * INSTR_MAX_HW;
    localparam int HW0_ENC_GROUP_HIGH = 15;
    localparam int HW0_ENC_GROUP_LOW  = 14;

    typedef logic [HW_WIDTH-1:0]    hw_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [1:0]             instr_len_t;

    typedef enum logic [1:0] {
        GROUP_0 = 2'd0,
        GROUP_1 = 2'd1,
        GROUP_2 = 2'd2,
        GROUP_3 = 2'd3
    } instr_group_t;

    // Every group encoding is legal, so the mapping is total.
    function automatic instr_len_t instr_len_from_group(instr_group_t group);
        instr_len_t len;
        case (group)
            GROUP_0: len = 2'd1;
            GROUP_1: len = 2'd2;
            GROUP_2: len = 2'd2;
            GROUP_3: len = 2'd3;
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instr_halfword_assembler_if.sv
// Bus between instruction memory / decoder and the halfword assembler.
// Carries the redirect (flush, flush_pc), the halfword input handshake
// (in_hw, in_valid, in_ready) and the assembled instruction output handshake
// (out_instr, out_len, out_pc, out_valid, out_ready).
//   master : the surrounding fetch environment (drives halfwords, consumes out_*)
//   slave  : the assembler itself
interface instr_halfword_assembler_if #(
    parameter int ADDR_WIDTH = 32
);
    import instr_halfword_assembler_pkg::*;

    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    hw_t                   in_hw;
    logic                  in_valid;
    logic                  in_ready;
    instr_t                out_instr;
    instr_len_t            out_len;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output flush, flush_pc, in_hw, in_valid, out_ready,
        input  in_ready, out_instr, out_len, out_pc, out_valid
    );

    modport slave (
        input  flush, flush_pc, in_hw, in_valid, out_ready,
        output in_ready, out_instr, out_len, out_pc, out_valid
    );

endinterface

// File: rtl/instr_halfword_assembler.sv
// Instruction halfword assembler: gathers 16-bit halfwords into one
// variable-length instruction (1..3 halfwords, length from the hw0 group
// field) and presents it zero-filled as {hw0,hw1,hw2} with its PC and length.
// Ports:
//   clk  - single clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of instr_halfword_assembler_if (flush/redirect,
//          halfword input handshake, instruction output handshake)
module instr_halfword_assembler
    import instr_halfword_assembler_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    instr_halfword_assembler_if.slave   bus
);

    hw_t                   hw_buf_q [INSTR_MAX_HW];
    hw_t                   hw_buf_d [INSTR_MAX_HW];
    logic [1:0]            cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] cur_pc_q,    cur_pc_d;
    instr_t                out_instr_q, out_instr_d;
    instr_len_t            out_len_q,   out_len_d;
    logic [ADDR_WIDTH-1:0] out_pc_q,    out_pc_d;
    logic                  out_valid_q, out_valid_d;

    instr_group_t group;
    instr_len_t   need;
    logic         complete;
    logic         xfer;
    logic         in_ready;
    logic         accept;

    // Length is only ever derived from the halfword sitting in slot 0.
    assign group    = instr_group_t'(hw_buf_q[0][HW0_ENC_GROUP_HIGH:HW0_ENC_GROUP_LOW]);
    assign need     = instr_len_from_group(group);
    assign complete = (cnt_q != 2'd0) && (cnt_q == need);
    assign xfer     = complete && (!out_valid_q || bus.out_ready);
    // Combinational through out_ready on purpose: a draining output frees the
    // buffer in the same cycle, which is what sustains one halfword per cycle.
    assign in_ready = !bus.flush && (!complete || xfer);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        hw_buf_d    = hw_buf_q;
        cnt_d       = cnt_q;
        cur_pc_d    = cur_pc_q;
        out_instr_d = out_instr_q;
        out_len_d   = out_len_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (bus.flush) begin
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
            cur_pc_d    = bus.flush_pc;
        end else begin
            if (xfer) begin
                for (int i = 0; i < INSTR_MAX_HW; i++) begin
                    out_instr_d[(INSTR_MAX_HW-1-i)*HW_WIDTH +: HW_WIDTH] =
                        (i < int'(need)) ? hw_buf_q[i] : '0;
                end
                out_len_d   = need;
                out_pc_d    = cur_pc_q;
                out_valid_d = 1'b1;
                cur_pc_d    = cur_pc_q + {{(ADDR_WIDTH-3){1'b0}}, need, 1'b0};
                cnt_d       = 2'd0;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end

            if (accept) begin
                if (xfer) begin
                    hw_buf_d[0] = bus.in_hw;
                    cnt_d       = 2'd1;
                end else begin
                    case (cnt_q)
                        2'd0:    hw_buf_d[0] = bus.in_hw;
                        2'd1:    hw_buf_d[1] = bus.in_hw;
                        default: hw_buf_d[2] = bus.in_hw;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hw_buf_q    <= '{default: '0};
            cnt_q       <= 2'd0;
            cur_pc_q    <= RESET_PC;
            out_instr_q <= '0;
            out_len_q   <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            hw_buf_q    <= hw_buf_d;
            cnt_q       <= cnt_d;
            cur_pc_q    <= cur_pc_d;
            out_instr_q <= out_instr_d;
            out_len_q   <= out_len_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_instr = out_instr_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_instr_halfword_assembler.sv
module tb_instr_halfword_assembler;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    instr_halfword_assembler_if #(.ADDR_WIDTH(32)) bus ();

    instr_halfword_assembler #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every consumed instruction, recorded as {instr, len, pc}.
    logic [81:0] out_q [$];

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            out_q.push_back({bus.out_instr, bus.out_len, bus.out_pc});
    end

    task automatic do_reset();
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        bus.in_valid = 1'b0;
        bus.in_hw    = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
    endtask

    task automatic send(input logic [15:0] hw);
        int n;
        n = 0;
        bus.in_hw    = hw;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_timeout hw=%h in_ready stayed %b", hw, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic get_out(input string name, input logic [47:0] ei,
                           input logic [1:0] el, input logic [31:0] ep);
        int n;
        logic [81:0] e;
        n = 0;
        while (out_q.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_q.size() == 0) begin
            errors++;
            $display("FAIL %s timeout: no instruction, expected instr=%h", name, ei);
            return;
        end
        e = out_q.pop_front();
        if (e[81:34] !== ei) begin
            errors++;
            $display("FAIL %s instr got=%h exp=%h", name, e[81:34], ei);
        end
        checks++;
        if (e[33:32] !== el) begin
            errors++;
            $display("FAIL %s len got=%0d exp=%0d", name, e[33:32], el);
        end
        checks++;
        if (e[31:0] !== ep) begin
            errors++;
            $display("FAIL %s pc got=%h exp=%h", name, e[31:0], ep);
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_instr !== 48'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
        checks++;
        if (bus.out_len !== 2'd0) begin errors++; $display("FAIL reset_out_len got=%0d exp=0", bus.out_len); end
        checks++;
        if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        send(16'h0123);
        get_out("single_g0", 48'h0123_0000_0000, 2'd1, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream [5];
        stream = '{16'h4001, 16'hBEEF, 16'h0002, 16'h8123, 16'h4567};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_hw    = stream[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready idx=%0d got=%b exp=1", i, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        get_out("b2b_0", 48'h4001_BEEF_0000, 2'd2, 32'h0);
        get_out("b2b_1", 48'h0002_0000_0000, 2'd1, 32'h4);
        get_out("b2b_2", 48'h8123_4567_0000, 2'd2, 32'h6);
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        send(16'hC010);
        send(16'h1234);
        send(16'h5678);
        send(16'h0007);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
            checks++;
            if (bus.out_instr !== 48'hC010_1234_5678) begin errors++; $display("FAIL hold_instr cyc=%0d got=%h exp=c01012345678", c, bus.out_instr); end
            checks++;
            if (bus.out_len !== 2'd3) begin errors++; $display("FAIL hold_len cyc=%0d got=%0d exp=3", c, bus.out_len); end
            checks++;
            if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL hold_pc cyc=%0d got=%h exp=0", c, bus.out_pc); end
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        get_out("bp_g3", 48'hC010_1234_5678, 2'd3, 32'h0);
        get_out("bp_next", 48'h0007_0000_0000, 2'd1, 32'h6);
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b0;
        send(16'h0021);
        send(16'hC010);
        send(16'h1234);
        bus.in_hw    = 16'h5555;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h100;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(16'h0009);
        get_out("flush_redirect", 48'h0009_0000_0000, 2'd1, 32'h100);
        repeat (4) @(negedge clk);
        checks++;
        if (out_q.size() != 0) begin errors++; $display("FAIL flush_stray got=%0d instrs exp=0", out_q.size()); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        send(16'h4000);
        send(16'h0001);
        send(16'h0005);
        get_out("wrap_0", 48'h4000_0001_0000, 2'd2, 32'hFFFF_FFFE);
        get_out("wrap_1", 48'h0005_0000_0000, 2'd1, 32'h0000_0002);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        send(16'h0011);
        send(16'hC000);
        send(16'h0001);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", bus.out_valid); end
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h40;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rstmid_out_pc got=%h exp=0", bus.out_pc); end
        checks++;
        if (bus.out_instr !== 48'h0) begin errors++; $display("FAIL rstmid_out_instr got=%h exp=0", bus.out_instr); end
        checks++;
        if (bus.out_len !== 2'd0) begin errors++; $display("FAIL rstmid_out_len got=%0d exp=0", bus.out_len); end
        out_q.delete();
        bus.out_ready = 1'b1;
        send(16'h0013);
        get_out("rstmid_after", 48'h0013_0000_0000, 2'd1, 32'h0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.in_hw     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_pc_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
